tt_pin_responder: RTL

//  Target-side responder for the host pin protocol used by the tile harness.
//  The host (bench or off-chip MCU) drives command/data bytes with a 4-phase
//  req/ack handshake; this block decodes them into reads and writes of a small

---
 rtl/tt_pin_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tt_pin_responder.sv
// tt_pin_responder: target side of the 4-phase req/ack host pin protocol.
// Decodes command/data bytes into reads and writes of a small register file.
`default_nettype none

module tt_pin_responder #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       req_in,
    input  logic [7:0] data_in,
    output logic       ack_out,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       err,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_BAD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK_CMD  = 2'd1,
        GET_DATA = 2'd2,
        ACK_DATA = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_prev;
    logic                   req_s;
    logic                   req_rise;
    logic [1:0]             cmd_op;
    logic [5:0]             cmd_addr;
    logic [7:0]             regs [DEPTH];
    logic                   in_legal;
    logic                   cmd_legal;
    logic                   take_cmd;
    logic                   take_data;

    assign req_s     = req_sync[SYNC_STAGES-1];
    assign req_rise  = req_s & ~req_prev;
    assign in_legal  = ({26'd0, data_in[5:0]} < DEPTH);
    assign cmd_legal = ({26'd0, cmd_addr} < DEPTH);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync <= '0;
            req_prev <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
            req_prev <= req_s;
        end
    end

    always_comb begin
        state_next = state;
        take_cmd   = 1'b0;
        take_data  = 1'b0;
        if (!ena) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_rise) begin
                        state_next = ACK_CMD;
                        take_cmd   = 1'b1;
                    end
                end
                ACK_CMD: begin
                    if (!req_s) begin
                        state_next = (cmd_op == OP_WRITE) ? GET_DATA : IDLE;
                    end
                end
                GET_DATA: begin
                    if (req_rise) begin
                        state_next = ACK_DATA;
                        take_data  = 1'b1;
                    end
                end
                ACK_DATA: begin
                    if (!req_s) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack_out  <= 1'b0;
            data_out <= 8'h00;
            data_oe  <= 1'b0;
            err      <= 1'b0;
            cmd_op   <= 2'b00;
            cmd_addr <= 6'd0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            state   <= state_next;
            // Registered from next state so ack never sees a combinational input path.
            ack_out <= (state_next == ACK_CMD) || (state_next == ACK_DATA);

            if (take_cmd) begin
                cmd_op   <= data_in[7:6];
                cmd_addr <= data_in[5:0];
                if (data_in[7:6] == OP_READ) begin
                    data_oe  <= 1'b1;
                    data_out <= in_legal ? regs[data_in[AW-1:0]] : 8'h00;
                    if (!in_legal) begin
                        err <= 1'b1;
                    end
                end else if (data_in[7:6] == OP_BAD) begin
                    err <= 1'b1;
                end
            end else if ((state == ACK_CMD) && (state_next != ACK_CMD)) begin
                data_oe <= 1'b0;
            end

            if (take_data) begin
                if (cmd_legal) begin
                    regs[cmd_addr[AW-1:0]] <= data_in;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
